// File: rtl/lane_serializer_4x8.sv
// lane_serializer_4x8: captures a 4-lane word and replays it as a 4-slot byte stream on one lane,
// counting words that arrive while the previous one is still being shifted out.
module lane_serializer_4x8 #(
    parameter int WIDTH        = 8,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic             clk_f,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_0,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic [WIDTH-1:0] data_3,
    input  logic             valid_0,
    input  logic             valid_1,
    input  logic             valid_2,
    input  logic             valid_3,
    output logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic [1:0]       lane_id,
    output logic             overrun_err,
    output logic [7:0]       drop_cnt
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state;
    logic [1:0]       r_slot;
    logic [WIDTH-1:0] r_hold_1, r_hold_2, r_hold_3;
    logic [3:1]       r_mask;
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid_out;
    logic [1:0]       r_lane_id;
    logic             r_overrun;
    logic [7:0]       r_drop_cnt;

    logic             w_any_v;
    logic             w_ready;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] w_hold_sel;
    logic             w_mask_sel;
    logic [WIDTH-1:0] w_lane0;
    logic [WIDTH-1:0] w_shift_byte;

    assign w_any_v      = valid_0 | valid_1 | valid_2 | valid_3;
    assign w_ready      = (r_state == IDLE) | (r_state == SHIFT && r_slot == 2'd3);
    assign w_next       = r_slot + 2'd1;
    // Lane 0 goes straight to the output at capture, so only lanes 1..3 are held
    assign w_hold_sel   = (w_next == 2'd1) ? r_hold_1 : (w_next == 2'd2) ? r_hold_2 : r_hold_3;
    assign w_mask_sel   = (w_next == 2'd1) ? r_mask[1] : (w_next == 2'd2) ? r_mask[2] : r_mask[3];
    assign w_lane0      = (ZERO_INVALID && !valid_0) ? '0 : data_0;
    assign w_shift_byte = (ZERO_INVALID && !w_mask_sel) ? '0 : w_hold_sel;

    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= IDLE;
            r_slot      <= 2'd0;
            r_hold_1    <= '0;
            r_hold_2    <= '0;
            r_hold_3    <= '0;
            r_mask      <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_lane_id   <= 2'd0;
            r_overrun   <= 1'b0;
            r_drop_cnt  <= 8'd0;
        end else begin
            if (w_ready && w_any_v) begin
                r_state     <= SHIFT;
                r_slot      <= 2'd0;
                r_hold_1    <= data_1;
                r_hold_2    <= data_2;
                r_hold_3    <= data_3;
                r_mask      <= {valid_3, valid_2, valid_1};
                r_data_out  <= w_lane0;
                r_valid_out <= valid_0;
                r_lane_id   <= 2'd0;
            end else if (r_state == SHIFT && r_slot != 2'd3) begin
                r_slot      <= w_next;
                r_data_out  <= w_shift_byte;
                r_valid_out <= w_mask_sel;
                r_lane_id   <= w_next;
            end else begin
                r_state     <= IDLE;
                r_slot      <= 2'd0;
                r_data_out  <= '0;
                r_valid_out <= 1'b0;
                r_lane_id   <= 2'd0;
            end
            if (!w_ready && w_any_v) begin
                r_overrun <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign ready       = w_ready;
    assign data_out    = r_data_out;
    assign valid_out   = r_valid_out;
    assign lane_id     = r_lane_id;
    assign overrun_err = r_overrun;
    assign drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_lane_serializer_4x8.sv
// tb_lane_serializer_4x8: scoreboard bench; expected slots are queued at each capture edge
// and checked one per cycle on the falling edge, together with ready/overrun/drop state.
module tb_lane_serializer_4x8;
    logic       clk_f = 1'b0;
    logic       reset_L;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic       valid_0, valid_1, valid_2, valid_3;
    logic       ready;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] lane_id;
    logic       overrun_err;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [10:0] sb_q[$];
    int exp_drop = 0;
    logic exp_err = 1'b0;

    lane_serializer_4x8 #(.WIDTH(8), .ZERO_INVALID(1'b1)) dut (
        .clk_f(clk_f), .reset_L(reset_L),
        .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
        .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
        .ready(ready), .data_out(data_out), .valid_out(valid_out), .lane_id(lane_id),
        .overrun_err(overrun_err), .drop_cnt(drop_cnt)
    );

    always #5 clk_f = ~clk_f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] slot_exp(input logic v, input logic [7:0] d, input logic [1:0] l);
        return {(v ? d : 8'h00), v, l};
    endfunction

    // Reference: a capture is possible only once the previous word's slots have all been shown
    always @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            sb_q.delete();
            exp_drop = 0;
            exp_err  = 1'b0;
        end else if (valid_0 | valid_1 | valid_2 | valid_3) begin
            if (sb_q.size() == 0) begin
                sb_q.push_back(slot_exp(valid_0, data_0, 2'd0));
                sb_q.push_back(slot_exp(valid_1, data_1, 2'd1));
                sb_q.push_back(slot_exp(valid_2, data_2, 2'd2));
                sb_q.push_back(slot_exp(valid_3, data_3, 2'd3));
            end else begin
                exp_err = 1'b1;
                if (exp_drop != 255) exp_drop++;
            end
        end
    end

    always @(negedge clk_f) begin
        logic [10:0] e;
        e = (sb_q.size() != 0) ? sb_q.pop_front() : 11'd0;
        chk("slot", {data_out, valid_out, lane_id}, {21'd0, e});
        chk("ready", {31'd0, ready}, {31'd0, sb_q.size() == 0});
        chk("overrun_err", {31'd0, overrun_err}, {31'd0, exp_err});
        chk("drop_cnt", {24'd0, drop_cnt}, exp_drop);
    end

    task automatic drive(input logic [3:0] v, input logic [31:0] d);
        {valid_3, valid_2, valid_1, valid_0} = v;
        {data_3, data_2, data_1, data_0} = d;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_f);
        #1;
    endtask

    initial begin
        reset_L = 1'b1;
        drive(4'h0, 32'h0);
        #1 reset_L = 1'b0;
        step(3);
        reset_L = 1'b1;
        step(3);
        chk("post_reset_ready", {31'd0, ready}, 32'd1);
        chk("post_reset_valid", {31'd0, valid_out}, 32'd0);

        drive(4'hF, 32'h44332211);
        step(1);
        drive(4'h0, 32'h0);
        step(6);

        drive(4'b0101, 32'hA3A2A1A0);
        step(1);
        drive(4'h0, 32'h0);
        step(6);

        drive(4'hF, 32'h04030201);
        step(1);
        drive(4'h0, 32'h0);
        step(3);
        drive(4'hF, 32'h08070605);
        step(1);
        drive(4'h0, 32'h0);
        step(6);

        drive(4'hF, $urandom);
        step(4);
        chk("drop_first_word", {24'd0, drop_cnt}, 32'd3);
        repeat (400) begin
            drive(4'hF, $urandom);
            step(1);
        end
        chk("drop_saturated", {24'd0, drop_cnt}, 32'd255);
        drive(4'h0, 32'h0);
        step(8);
        chk("overrun_sticky", {31'd0, overrun_err}, 32'd1);

        repeat (20) begin
            drive(4'h0, $urandom);
            step(1);
        end
        chk("idle_drop_held", {24'd0, drop_cnt}, 32'd255);

        drive(4'hF, 32'hD3D2D1D0);
        step(1);
        drive(4'h0, 32'h0);
        step(1);
        chk("mid_word_lane", {30'd0, lane_id}, 32'd1);
        #1 reset_L = 1'b0;
        #1;
        chk("async_rst_data", {24'd0, data_out}, 32'd0);
        chk("async_rst_valid", {31'd0, valid_out}, 32'd0);
        chk("async_rst_lane", {30'd0, lane_id}, 32'd0);
        chk("async_rst_err", {31'd0, overrun_err}, 32'd0);
        chk("async_rst_drop", {24'd0, drop_cnt}, 32'd0);
        step(2);
        reset_L = 1'b1;
        step(3);
        chk("release_ready", {31'd0, ready}, 32'd1);
        chk("release_valid", {31'd0, valid_out}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
